// File: rtl/data_derotator.sv
// Inverse byte-transpose: gathers up to 16 column words, then emits 8 rebuilt row words.
// Column c, byte r (upper 64 bits only) becomes row r, byte c; unfilled columns read as 0x00.
module data_derotator #(
  parameter int WORD_SIZE = 128,
  parameter int ROWS      = 8,
  parameter int MAX_COLS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           channel,
  input  logic                 DI_valid,
  output logic                 DI_ready,
  input  logic [WORD_SIZE-1:0] DI,
  output logic                 DO_valid,
  input  logic                 DO_ready,
  output logic [WORD_SIZE-1:0] DO,
  output logic                 DO_last
);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t           state, state_d;
  logic [3:0]       col_cnt;
  logic [2:0]       row_cnt, row_next;
  logic [4:0]       ch_q, ch_clamped, ch_eff;
  logic [15:0][7:0] row_buf   [ROWS];
  logic [15:0][7:0] row_buf_d [ROWS];
  logic [7:0][7:0]  di_hi;
  logic             accept, last_col, row_hs, unused_lo;

  assign di_hi      = DI[WORD_SIZE-1 -: 64];
  assign unused_lo  = ^DI[WORD_SIZE-65:0];
  assign DI_ready   = (state == COLLECT);
  assign accept     = DI_valid & DI_ready;
  assign row_hs     = DO_valid & DO_ready;
  assign row_next   = row_cnt + 3'd1;
  assign ch_clamped = (channel == 5'd0 || channel > 5'(MAX_COLS)) ? 5'(MAX_COLS) : channel;
  // The first column of a block uses the channel value being latched on that same edge
  assign ch_eff     = (col_cnt == 4'd0) ? ch_clamped : ch_q;
  assign last_col   = accept && ({1'b0, col_cnt} == ch_eff - 5'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      COLLECT: if (last_col) state_d = EMIT;
      EMIT:    if (row_hs && row_cnt == 3'(ROWS-1)) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Next buffer contents; column 0 wipes the previous block so nothing leaks forward
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_buf_d[r] = row_buf[r];
      if (accept) begin
        if (col_cnt == 4'd0) row_buf_d[r] = '0;
        row_buf_d[r][4'd15 - col_cnt] = di_hi[3'(7 - r)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      ch_q     <= 5'(MAX_COLS);
      DO       <= '0;
      DO_valid <= 1'b0;
      DO_last  <= 1'b0;
      for (int r = 0; r < ROWS; r++) row_buf[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) row_buf[r] <= row_buf_d[r];
      if (accept) begin
        col_cnt <= last_col ? 4'd0 : col_cnt + 4'd1;
        if (col_cnt == 4'd0) ch_q <= ch_clamped;
      end
      // Row 0 is taken from the next-state buffer so the last column is already merged in
      if (last_col) begin
        DO       <= row_buf_d[0];
        DO_valid <= 1'b1;
        DO_last  <= 1'b0;
        row_cnt  <= '0;
      end else if (row_hs) begin
        if (row_cnt == 3'(ROWS-1)) begin
          row_cnt  <= '0;
          DO_valid <= 1'b0;
          DO_last  <= 1'b0;
        end else begin
          row_cnt <= row_next;
          DO      <= row_buf[row_next];
          DO_last <= (row_next == 3'(ROWS-1));
        end
      end
    end
  end

endmodule

// File: tb/tb_data_derotator.sv
// Self-checking bench for data_derotator: table-driven vectors, directed corner sequences,
// and randomized blocks checked against a byte-permutation reference model.
module tb_data_derotator;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   channel;
  logic         DI_valid;
  logic         DI_ready;
  logic [127:0] DI;
  logic         DO_valid;
  logic         DO_ready;
  logic [127:0] DO;
  logic         DO_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] cols     [16];
  logic [127:0] exp_rows [8];
  logic [127:0] got_rows [8];

  typedef struct {
    logic [4:0]   ch;
    int           ncols;
    logic [127:0] row2;
  } vec_t;

  vec_t vecs [5];

  data_derotator dut (
    .clk      (clk),
    .rst      (rst),
    .channel  (channel),
    .DI_valid (DI_valid),
    .DI_ready (DI_ready),
    .DI       (DI),
    .DO_valid (DO_valid),
    .DO_ready (DO_ready),
    .DO       (DO),
    .DO_last  (DO_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: row r byte c is column c byte r for c < n, zero otherwise
  task automatic computeExpected(input int n);
    for (int r = 0; r < 8; r++) begin
      exp_rows[r] = '0;
      for (int c = 0; c < n; c++) begin
        logic [7:0] b;
        b = 8'(cols[c] >> (120 - 8 * r));
        exp_rows[r] = exp_rows[r] | (128'(b) << (120 - 8 * c));
      end
    end
  endtask

  task automatic fillPattern();
    for (int c = 0; c < 16; c++) begin
      cols[c] = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int r = 0; r < 8; r++) cols[c][127 - 8 * r -: 8] = 8'((r << 4) | c);
    end
  endtask

  task automatic fillRandom();
    for (int c = 0; c < 16; c++) cols[c] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic int clampCh(input logic [4:0] ch);
    return (ch == 0 || ch > 16) ? 16 : int'(ch);
  endfunction

  task automatic applyStimulus(input logic [4:0] ch, input int n, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < n) begin
      @(negedge clk);
      if (cyc > 400) begin
        checkOutput("collect_timeout", 128'(idx), 128'(n));
        break;
      end
      checkOutput("collect_di_ready", 128'(DI_ready), 128'(1));
      checkOutput("collect_do_valid", 128'(DO_valid), 128'(0));
      DI       = cols[idx];
      channel  = (idx == 0) ? ch : 5'($urandom_range(0, 31));
      DI_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (DI_valid) idx++;
      cyc++;
    end
  endtask

  task automatic drainRows(input int nrows, input bit bp, input int stall_row, input bit hold_valid);
    int rows  = 0;
    int cyc   = 0;
    int stall = 0;
    while (rows < nrows) begin
      @(negedge clk);
      if (cyc > 400) begin
        checkOutput("emit_timeout", 128'(rows), 128'(nrows));
        break;
      end
      DI_valid = hold_valid;
      DI       = {$urandom, $urandom, $urandom, $urandom};
      channel  = 5'($urandom_range(0, 31));
      checkOutput("emit_do_valid", 128'(DO_valid), 128'(1));
      checkOutput("emit_di_ready", 128'(DI_ready), 128'(0));
      checkOutput($sformatf("emit_row%0d_data", rows), DO, exp_rows[rows]);
      checkOutput($sformatf("emit_row%0d_last", rows), 128'(DO_last), 128'(rows == 7));
      got_rows[rows] = DO;
      if (rows == stall_row && stall < 5) begin
        DO_ready = 1'b0;
        stall++;
      end else begin
        DO_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk);
      if (DO_ready) rows++;
      cyc++;
    end
  endtask

  task automatic runBlock(input logic [4:0] ch, input int n, input bit gaps, input bit bp,
                          input int stall_row, input bit hold_valid);
    computeExpected(n);
    applyStimulus(ch, n, gaps);
    drainRows(8, bp, stall_row, hold_valid);
    @(negedge clk);
    checkOutput("post_block_do_valid", 128'(DO_valid), 128'(0));
    checkOutput("post_block_di_ready", 128'(DI_ready), 128'(1));
    DI_valid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_di_ready"}, 128'(DI_ready), 128'(1));
    checkOutput({tag, "_do_valid"}, 128'(DO_valid), 128'(0));
    checkOutput({tag, "_do_last"},  128'(DO_last),  128'(0));
    checkOutput({tag, "_do"},       DO,             128'(0));
  endtask

  initial begin
    rst      = 1'b1;
    channel  = 5'd0;
    DI_valid = 1'b0;
    DI       = '0;
    DO_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    vecs[0] = '{5'd16, 16, 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F};
    vecs[1] = '{5'd3,  3,  128'h2021_2200_0000_0000_0000_0000_0000_0000};
    vecs[2] = '{5'd0,  16, 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F};
    vecs[3] = '{5'd20, 16, 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F};
    vecs[4] = '{5'd1,  1,  128'h2000_0000_0000_0000_0000_0000_0000_0000};

    fillPattern();
    for (int i = 0; i < 5; i++) begin
      runBlock(vecs[i].ch, vecs[i].ncols, 1'b0, 1'b0, -1, 1'b0);
      checkOutput($sformatf("vec%0d_row2", i), got_rows[2], vecs[i].row2);
    end

    $display("[TB] backpressure at row 4");
    fillRandom();
    runBlock(5'd16, 16, 1'b0, 1'b0, 4, 1'b0);

    $display("[TB] input gaps and EMIT lockout");
    fillRandom();
    runBlock(5'd7, 7, 1'b1, 1'b0, -1, 1'b1);
    fillRandom();
    runBlock(5'd5, 5, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] randomized blocks");
    for (int k = 0; k < 20; k++) begin
      logic [4:0] ch;
      ch = 5'($urandom_range(0, 31));
      fillRandom();
      runBlock(ch, clampCh(ch), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
               1'($urandom_range(0, 1)));
    end

    $display("[TB] reset after 5 columns");
    fillRandom();
    applyStimulus(5'd16, 5, 1'b0);
    @(negedge clk);
    DI_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("rst_collect");
    fillRandom();
    runBlock(5'd2, 2, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] reset during EMIT at row 3");
    fillRandom();
    computeExpected(16);
    applyStimulus(5'd16, 16, 1'b0);
    drainRows(3, 1'b0, -1, 1'b0);
    @(negedge clk);
    checkOutput("rst_emit_pre_row3", DO, exp_rows[3]);
    DO_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("rst_emit");
    DO_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_emit_no_stale", 128'(DO_valid), 128'(0));
    end
    fillRandom();
    runBlock(5'd2, 2, 1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_derotator.md
Name: data_derotator

Overview:
- Inverse of the byte-transpose rotator: collects column words and rebuilds row words from them.
- Each column word carries one byte from each of 8 rows in its upper 64 bits.
- After `channel` columns have been accepted, emits 8 reassembled 128-bit row words, row 0 first.
- Sits on the write-back path after the processing array, before the output buffer/DMA.

Parameters:
- WORD_SIZE, 128, data word width in bits; fixed at 128 for this block.
- ROWS, 8, number of row words rebuilt per block; fixed at 8.
- MAX_COLS, 16, maximum columns per block (WORD_SIZE/8).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- channel  input  5  number of columns per block, 1..16; 0 or >16 treated as 16; sampled when the first column of a block is accepted.
- DI_valid  input  1  column word valid.
- DI_ready  output  1  block can accept a column (high only in COLLECT).
- DI  input  128  column word; byte r = DI[127-8r -: 8], r = 0..7; DI[63:0] ignored.
- DO_valid  output  1  row word valid.
- DO_ready  input  1  downstream accepts row word.
- DO  output  128  row word; byte c = DO[127-8c -: 8], c = 0..15.
- DO_last  output  1  high with DO_valid on row 7.

Behaviour:
- Reset (sync, rst=1 at posedge), values in effect after that edge:
  - State = COLLECT; col_cnt = 0; row_cnt = 0.
  - All 8 row buffers = 0; latched channel = 16.
  - DI_ready = 1; DO_valid = 0; DO_last = 0; DO = 0.
- Reset wins over every other event. A reset mid-block discards partial data; no stale row is emitted afterwards.
- Register transfers: DO, DO_valid and DO_last are registered; DI_ready is a combinational decode of state.
- COLLECT state:
  - A column is accepted on any cycle with DI_valid & DI_ready.
  - On acceptance at col_cnt = c, buffer[r] byte c <= DI byte r, for all r.
  - If c = 0: latch the clamped channel value, and clear bytes 1..15 of every buffer in the same cycle. Unfilled columns therefore read back as 0x00, never as data from a previous block.
  - col_cnt increments on each acceptance.
  - When c = latched channel − 1 (for c = 0, use the channel value being latched that cycle): col_cnt <= 0 and go to EMIT.
- EMIT state:
  - DI_ready = 0; DI_valid is ignored.
  - DO = buffer[row_cnt]; DO_valid = 1 starting the cycle after the last column is accepted (1-cycle latency).
  - DO_last = (row_cnt == 7).
  - On DO_valid & DO_ready: row_cnt increments. DO must update to the next row on the same edge, so back-to-back rows go out with DO_ready held high.
  - While DO_ready = 0: DO, DO_valid and DO_last hold stable.
  - On the handshake of row 7: row_cnt <= 0, DO_valid <= 0, return to COLLECT. DI_ready is high the following cycle; no overlap of EMIT with the next block.
- Minimum cost: a full 16-column block takes 16 cycles in and 8 cycles out, plus 1 cycle from the last column to the first row.
- channel is ignored except on the first column of a block. Changing it mid-block has no effect.
- Width rule: each byte is an exact copy with no arithmetic. The transform is a pure byte permutation: DO_row[r] byte c = DI_col[c] byte r.

Test Plan:
- Full block: channel=16; column c = {8 bytes (r<<4)|c, 64'hFFFF_FFFF_FFFF_FFFF}, DO_ready=1 -> row r = 16 bytes (r<<4)|c for c=0..15, e.g. row 2 = 128'h202122...2F. First DO_valid arrives 1 cycle after the 16th acceptance; DO_last only on row 7; the lower-64 garbage never appears.
- Partial block: channel=3, same column pattern -> row r = {(r<<4)|0, (r<<4)|1, (r<<4)|2, 13 bytes 0x00}. A preceding full block must not leak any bytes into columns 3..15.
- Backpressure: channel=16, DO_ready low for 5 cycles at row 4 -> DO, DO_valid and DO_last are stable throughout. Rows 4..7 then emerge in order; DI_ready stays 0 until row 7 handshakes.
- Input gaps and lockout: DI_valid toggling 1/0 during COLLECT -> only valid cycles are counted. DI_valid held high during EMIT -> no column captured; next block starts cleanly at col_cnt=0.
- Channel edge values: channel=0 and channel=20 -> both behave as 16. channel=1 -> row r = {byte r of column 0, 15×0x00}; DO_valid comes 1 cycle after the single acceptance.
- Reset mid-operation: assert rst after 5 columns, and separately during EMIT at row 3 -> next cycle DO_valid=0 and DI_ready=1. A new channel=2 block then produces correct rows with zeros in columns 2..15.
